// File: rtl/shared_bus_arbiter_pkg.sv
// Shared state encoding and helpers for the video/CPU RAM bus arbiter.
// Purely declarative; no timing or flow-control behaviour of its own.
package shared_bus_arbiter_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_VID        = 3'd1;
  localparam logic [2:0] ST_CPU_SETUP  = 3'd2;
  localparam logic [2:0] ST_CPU_STROBE = 3'd3;
  localparam logic [2:0] ST_CPU_DONE   = 3'd4;

  localparam logic [2:0] STARVE_CNT_SAT = 3'd7;

  function automatic logic is_cpu_state(input logic [2:0] st);
    return (st == ST_CPU_SETUP) || (st == ST_CPU_STROBE) || (st == ST_CPU_DONE);
  endfunction

endpackage

// File: rtl/ttl_74257_noHiZout.sv
// Quad-style 2:1 mux without tristate: disabled output reads as all ones.
// Combinational, zero latency; no backpressure.
module ttl_74257_noHiZout #(
  parameter int BLOCKS = 4
) (
  input  logic [BLOCKS-1:0] A,
  input  logic [BLOCKS-1:0] B,
  input  logic              Select,
  input  logic              Enable_bar,
  output logic [BLOCKS-1:0] Y
);

  assign Y = Enable_bar ? {BLOCKS{1'b1}} : (Select ? B : A);

endmodule

// File: rtl/shared_bus_arbiter.sv
// Arbitrates one RAM bus between a video scanner and a CPU; video 1-cycle slot, CPU 3-cycle access.
// Requesters hold req until ack; a CPU starved past STARVE_MAX wait cycles overrides video.
module shared_bus_arbiter
  import shared_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 11,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  output logic              mux_sel,
  output logic              mux_en_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we_n
);

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic [2:0] r_starve_cnt;
  logic       r_mux_sel;
  logic       r_wr_lat;
  logic       w_starve;
  logic       w_mux_en_n;

  assign w_starve = ({29'b0, r_starve_cnt} >= STARVE_MAX);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (vid_req && !w_starve) begin
          w_next = ST_VID;
        end else if (cpu_req) begin
          w_next = ST_CPU_SETUP;
        end
      end
      ST_VID:        w_next = ST_IDLE;
      ST_CPU_SETUP:  w_next = ST_CPU_STROBE;
      ST_CPU_STROBE: w_next = ST_CPU_DONE;
      ST_CPU_DONE:   w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= 3'd0;
      r_mux_sel    <= 1'b0;
      r_wr_lat     <= 1'b0;
    end else begin
      r_state <= w_next;
      // Only cycles where the CPU is actually kept off the bus count as starvation.
      if (w_next == ST_CPU_SETUP) begin
        r_starve_cnt <= 3'd0;
      end else if (((r_state == ST_IDLE) || (r_state == ST_VID)) && cpu_req &&
                   (r_starve_cnt != STARVE_CNT_SAT)) begin
        r_starve_cnt <= r_starve_cnt + 3'd1;
      end
      if (r_state == ST_CPU_SETUP) begin
        r_wr_lat <= cpu_wr;
      end
      // Select is registered so it keeps pointing at the last owner through IDLE.
      if (w_next == ST_VID) begin
        r_mux_sel <= 1'b0;
      end else if (is_cpu_state(w_next)) begin
        r_mux_sel <= 1'b1;
      end
    end
  end

  assign w_mux_en_n = (r_state == ST_IDLE);
  assign mux_en_n   = w_mux_en_n;
  assign mux_sel    = r_mux_sel;
  assign vid_ack    = (r_state == ST_VID);
  assign cpu_ack    = (r_state == ST_CPU_DONE);
  assign ram_we_n   = !((r_state == ST_CPU_STROBE) && r_wr_lat);
  assign cpu_wait_n = !(cpu_req && (r_state != ST_CPU_DONE));

  ttl_74257_noHiZout #(
    .BLOCKS(ADDR_W)
  ) u_addr_mux (
    .A         (vid_addr),
    .B         (cpu_addr),
    .Select    (r_mux_sel),
    .Enable_bar(w_mux_en_n),
    .Y         (ram_addr)
  );

endmodule
